ps_inv_seq: RTL and testbench

Column-serial inverse substitution layer for the Ascon-AEAD128 core. It accepts a 320-bit state and applies the inverse Ascon 5-bit S-box to every one of the 64 bit-columns, COLS_PER_CYCLE columns per clock. Results are returned through a valid/ready handshake. It sits on the debug and verification side of the permutation datapath, where it unwinds the substitution step for round-by-round state checking and self-test.

---
 rtl/ascon_aead128_pkg.sv | 27 ++
 rtl/inv_sbox.sv | 12 +
 rtl/ps_inv_seq.sv | 100 ++++++++++
 tb/tb_ps_inv_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the Ascon-AEAD128 core.
// Holds the 320-bit state layout, the inverse S-box table and the inverse-layer FSM encoding.
package ascon_aead128_pkg;

  // s0 occupies the most significant 64 bits.
  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } ascon_state;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ps_inv_state_t;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

endpackage

// File: rtl/inv_sbox.sv
// Inverse Ascon S-box for a single 5-bit column.
// The column is ordered {s0, s1, s2, s3, s4}, with s0 as the MSB.
module inv_sbox
  import ascon_aead128_pkg::*;
(
  input  logic [4:0] col,
  output logic [4:0] inv_col
);

  assign inv_col = INV_SBOX[col];

endmodule

// File: rtl/ps_inv_seq.sv
// Column-serial inverse substitution layer: inverts COLS_PER_CYCLE bit-columns per clock
// in place in a working register, then presents the result through a valid/ready handshake.
module ps_inv_seq
  import ascon_aead128_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  ascon_state in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output ascon_state out_state,
  output logic       busy
);

  localparam int unsigned NumSlices = 64 / COLS_PER_CYCLE;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  ps_inv_state_t   state_q;
  logic [CntW-1:0] col_cnt_q;
  ascon_state      work_q;

  logic [5:0]  base;
  logic [4:0]  lane_in  [COLS_PER_CYCLE];
  logic [4:0]  lane_out [COLS_PER_CYCLE];
  logic [63:0] nx0, nx1, nx2, nx3, nx4;
  ascon_state  upd;

  assign base = 6'(int'(col_cnt_q) * COLS_PER_CYCLE);

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign lane_in[l] = {work_q.s0[base + 6'(l)], work_q.s1[base + 6'(l)],
                         work_q.s2[base + 6'(l)], work_q.s3[base + 6'(l)],
                         work_q.s4[base + 6'(l)]};

    inv_sbox u_inv_sbox (
      .col     (lane_in[l]),
      .inv_col (lane_out[l])
    );
  end

  // Each column takes its lane result only in the cycle its slice is selected.
  for (genvar c = 0; c < 64; c++) begin : g_wb
    localparam int unsigned Lane = c % COLS_PER_CYCLE;
    localparam int unsigned Slot = c / COLS_PER_CYCLE;
    logic hit;

    assign hit    = (col_cnt_q == CntW'(Slot));
    assign nx0[c] = hit ? lane_out[Lane][4] : work_q.s0[c];
    assign nx1[c] = hit ? lane_out[Lane][3] : work_q.s1[c];
    assign nx2[c] = hit ? lane_out[Lane][2] : work_q.s2[c];
    assign nx3[c] = hit ? lane_out[Lane][1] : work_q.s3[c];
    assign nx4[c] = hit ? lane_out[Lane][0] : work_q.s4[c];
  end

  assign upd = {nx0, nx1, nx2, nx3, nx4};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      col_cnt_q <= '0;
      work_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q    <= in_state;
            col_cnt_q <= '0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          work_q <= upd;
          // Counter parks on the last slice instead of wrapping.
          if (col_cnt_q == LastCnt) begin
            state_q <= StDone;
          end else begin
            col_cnt_q <= col_cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign out_state = work_q;

endmodule

// File: tb/tb_ps_inv_seq.sv
// Scoreboard bench for ps_inv_seq with three instances (8, 1 and 64 columns per cycle).
module tb_ps_inv_seq;
  import ascon_aead128_pkg::*;

  localparam int ND = 3;
  localparam int unsigned CPC [ND] = '{8, 1, 64};

  // Forward Ascon S-box; the expected inverse is obtained by searching it.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  typedef struct {
    ascon_state exp;
    ascon_state orig;
    int         t_in;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid  [ND];
  logic       in_ready  [ND];
  logic       out_valid [ND];
  logic       out_ready [ND];
  logic       busy      [ND];
  ascon_state in_state  [ND];
  ascon_state out_state [ND];

  item_t exp_q [ND][$];
  int    out_t0 [$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] get_col(input ascon_state s, input int i);
    return {s.s0[i], s.s1[i], s.s2[i], s.s3[i], s.s4[i]};
  endfunction

  function automatic ascon_state put_col(input ascon_state s, input int i, input logic [4:0] v);
    ascon_state r = s;
    r.s0[i] = v[4]; r.s1[i] = v[3]; r.s2[i] = v[2]; r.s3[i] = v[1]; r.s4[i] = v[0];
    return r;
  endfunction

  function automatic ascon_state fwd(input ascon_state s);
    ascon_state r = s;
    for (int i = 0; i < 64; i++) r = put_col(r, i, SBOX[get_col(s, i)]);
    return r;
  endfunction

  function automatic ascon_state inv(input ascon_state s);
    ascon_state r = s;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++)
        if (SBOX[j] == get_col(s, i)) r = put_col(r, i, 5'(j));
    return r;
  endfunction

  function automatic ascon_state rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ps_inv_seq #(.COLS_PER_CYCLE(CPC[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );

    // Monitor: latency on the rising edge of out_valid, contents on the handshake.
    bit    prev_ov = 1'b0;
    item_t it;
    always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid[g] && !prev_ov) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out[%0d]: out_valid=1 expected no result", g);
          end else begin
            chk($sformatf("latency[%0d]", g), 320'(cyc - exp_q[g][0].t_in),
                320'(1 + 64 / CPC[g]));
          end
        end
        if (out_valid[g] && out_ready[g] && exp_q[g].size() > 0) begin
          it = exp_q[g].pop_front();
          chk($sformatf("out_state[%0d]", g), out_state[g], it.exp);
          chk($sformatf("ps_roundtrip[%0d]", g), fwd(out_state[g]), it.orig);
          if (g == 0) out_t0.push_back(cyc);
        end
        prev_ov = out_valid[g];
      end
    end
  end

  // Caller is at a negedge; returns at the negedge after the accepting cycle.
  task automatic send(input int d, input ascon_state st, input ascon_state ex);
    item_t e;
    in_valid[d] = 1'b1;
    in_state[d] = st;
    for (int k = 0; k < 200 && !in_ready[d]; k++) @(negedge clk);
    chk($sformatf("accept[%0d]", d), in_ready[d], 1'b1);
    if (in_ready[d]) begin
      e.exp = ex;
      e.orig = st;
      e.t_in = cyc;
      exp_q[d].push_back(e);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int pend;
    for (int k = 0; k < 10000; k++) begin
      pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      if (pend == 0) break;
      @(negedge clk);
    end
    pend = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    chk("drain_pending", 320'(pend), 320'(0));
  endtask

  task automatic rand_run(input int d, input int n);
    ascon_state st;
    for (int i = 0; i < n; i++) begin
      st = rand_state();
      send(d, st, inv(st));
    end
  endtask

  initial begin
    ascon_state st, ex;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      out_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1'b1);
      chk($sformatf("rst_out_valid[%0d]", d), out_valid[d], 1'b0);
      chk($sformatf("rst_busy[%0d]", d), busy[d], 1'b0);
      chk($sformatf("rst_out_state[%0d]", d), out_state[d], '0);
    end

    // Test 1: all-zero columns map to 0x14
    ex = '{s0: '1, s1: '0, s2: '1, s3: '0, s4: '0};
    for (int d = 0; d < ND; d++) send(d, '0, ex);
    drain();

    // Test 2: all columns 0x0b map to 0x01
    st = '{s0: '0, s1: '1, s2: '0, s3: '1, s4: '1};
    ex = '{s0: '0, s1: '0, s2: '0, s3: '0, s4: '1};
    for (int d = 0; d < ND; d++) send(d, st, ex);
    drain();

    // Test 3: random states, round trip through the forward layer
    fork
      rand_run(0, 200);
      rand_run(1, 30);
      rand_run(2, 300);
    join
    drain();

    // Test 4: back-pressure in DONE
    out_ready[0] = 1'b0;
    st = rand_state();
    ex = inv(st);
    send(0, st, ex);
    for (int k = 0; k < 20 && !out_valid[0]; k++) @(negedge clk);
    chk("t4_reach_done", out_valid[0], 1'b1);
    for (int k = 0; k < 20; k++) begin
      in_valid[0] = 1'b1;
      in_state[0] = ~st;
      chk("t4_hold_valid", out_valid[0], 1'b1);
      chk("t4_hold_state", out_state[0], ex);
      chk("t4_in_ready", in_ready[0], 1'b0);
      @(negedge clk);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4_ready_after_hs", in_ready[0], 1'b1);
    repeat (15) @(negedge clk);
    drain();

    // Test 5: reset while RUN is on slice 3
    st = rand_state();
    send(0, st, inv(st));
    repeat (3) @(negedge clk);
    chk("t5_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) exp_q[d].delete();
    chk("t5_in_ready", in_ready[0], 1'b1);
    chk("t5_out_valid", out_valid[0], 1'b0);
    chk("t5_busy_low", busy[0], 1'b0);
    repeat (12) @(negedge clk);
    st = rand_state();
    send(0, st, inv(st));
    drain();

    // Test 6: back-to-back throughput on the 8-column instance
    out_t0.delete();
    for (int i = 0; i < 5; i++) begin
      st = rand_state();
      send(0, st, inv(st));
    end
    drain();
    chk("t6_count", 320'(out_t0.size()), 320'(5));
    for (int i = 1; i < out_t0.size(); i++)
      chk($sformatf("t6_interval_%0d", i), 320'(out_t0[i] - out_t0[i-1]), 320'(10));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
